dds_sweep_ctrl: RTL and testbench

Sequencing controller that sits in front of `dds_core` and drives its `freq_word`, `wave_sel` and `dc_level` inputs. It accepts one configuration at a time over a valid/ready handshake and runs one of four modes: fixed tone, single linear sweep, repeating sweep, or up/down (ping-pong) sweep. Frequency steps are timed in DAC sample periods via `sample_tick`, so dwell time is independent of the system clock.

---
 rtl/dds_pkg.sv | 31 +++
 rtl/dds_dwell_timer.sv | 32 +++
 rtl/dds_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types, wave codes and parking constants for the DDS sweep controller
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED    = 2'd0,
    MODE_SINGLE   = 2'd1,
    MODE_REPEAT   = 2'd2,
    MODE_PINGPONG = 2'd3
  } sweep_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD      = 2'd1,
    ST_SWEEP_FWD = 2'd2,
    ST_SWEEP_REV = 2'd3
  } ctrl_state_t;

  localparam logic [2:0] WAVE_SINE     = 3'd0;
  localparam logic [2:0] WAVE_SQUARE   = 3'd1;
  localparam logic [2:0] WAVE_TRIANGLE = 3'd2;
  localparam logic [2:0] WAVE_SAW      = 3'd3;
  localparam logic [2:0] WAVE_DC       = 3'd4;

  // Mid-scale DAC code for a given resolution; used as the parked DC level.
  function automatic int amp_mid(input int width);
    return 1 << (width - 1);
  endfunction

  localparam int AMP_MID = amp_mid(12);

endpackage

// File: rtl/dds_dwell_timer.sv
// rtl/dds_dwell_timer.sv - counts sample ticks and pulses step once per dwell
module dds_dwell_timer #(
  parameter int DWELL_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   tick,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic                   step
);

  logic [DWELL_WIDTH-1:0] count;
  logic [DWELL_WIDTH-1:0] last;

  // A dwell of zero behaves as a dwell of one sample.
  assign last = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
  assign step = enable && tick && (count == last);

  // Tick counter; clear wins so a tick in the load cycle is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= step ? '0 : count + DWELL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - sequencing controller driving dds_core frequency, wave and DC level
import dds_pkg::*;

module dds_sweep_ctrl #(
  parameter int FREQ_WIDTH  = 16,
  parameter int DWELL_WIDTH = 20,
  parameter int AMP_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_mode,
  input  logic [FREQ_WIDTH-1:0]  cfg_start_freq,
  input  logic [FREQ_WIDTH-1:0]  cfg_stop_freq,
  input  logic [FREQ_WIDTH-1:0]  cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [2:0]             cfg_wave_sel,
  input  logic [AMP_WIDTH-1:0]   cfg_dc_level,
  input  logic                   abort,
  output logic [FREQ_WIDTH-1:0]  freq_word,
  output logic [2:0]             wave_sel,
  output logic [AMP_WIDTH-1:0]   dc_level,
  output logic                   busy,
  output logic                   step_strobe,
  output logic                   sweep_done
);

  localparam logic [AMP_WIDTH-1:0] DC_PARK = AMP_WIDTH'(amp_mid(AMP_WIDTH));

  ctrl_state_t state, state_nxt;
  sweep_mode_t mode_r;
  logic [FREQ_WIDTH-1:0]  start_r, stop_r, step_r;
  logic [DWELL_WIDTH-1:0] dwell_r;

  logic                   accept, sweeping, step_evt, arrival;
  logic [FREQ_WIDTH-1:0]  target, stepped;
  logic [FREQ_WIDTH:0]    cur_x, tgt_x, step_x, up_sum, dn_gap;

  logic [FREQ_WIDTH-1:0]  freq_nxt;
  logic [2:0]             wave_nxt;
  logic [AMP_WIDTH-1:0]   dc_nxt;
  logic                   strobe_nxt, done_nxt;

  assign sweeping  = (state == ST_SWEEP_FWD) || (state == ST_SWEEP_REV);
  assign busy      = sweeping;
  assign cfg_ready = ((state == ST_IDLE) || (state == ST_HOLD)) && !abort;
  assign accept    = cfg_valid && cfg_ready;

  dds_dwell_timer #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (abort || accept),
    .enable (sweeping && !abort),
    .tick   (sample_tick),
    .dwell  (dwell_r),
    .step   (step_evt)
  );

  // Move one step toward the target on an extra bit so nothing wraps, then clamp.
  always_comb begin
    target  = (state == ST_SWEEP_REV) ? start_r : stop_r;
    cur_x   = {1'b0, freq_word};
    tgt_x   = {1'b0, target};
    step_x  = {1'b0, step_r};
    up_sum  = cur_x + step_x;
    dn_gap  = cur_x - tgt_x;
    arrival = (freq_word == target);
    stepped = freq_word;
    if (tgt_x > cur_x) begin
      stepped = (up_sum >= tgt_x) ? target : up_sum[FREQ_WIDTH-1:0];
    end else if (tgt_x < cur_x) begin
      stepped = (dn_gap <= step_x) ? target : (freq_word - step_r);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next output values; abort beats accept beats a step event.
  always_comb begin
    state_nxt  = state;
    freq_nxt   = freq_word;
    wave_nxt   = wave_sel;
    dc_nxt     = dc_level;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
      freq_nxt  = '0;
      wave_nxt  = WAVE_DC;
      dc_nxt    = DC_PARK;
    end else if (accept) begin
      freq_nxt  = cfg_start_freq;
      wave_nxt  = cfg_wave_sel;
      dc_nxt    = cfg_dc_level;
      state_nxt = (sweep_mode_t'(cfg_mode) == MODE_FIXED) ? ST_HOLD : ST_SWEEP_FWD;
    end else if (step_evt) begin
      if (arrival) begin
        case (mode_r)
          MODE_SINGLE: begin
            done_nxt  = 1'b1;
            state_nxt = ST_HOLD;
          end
          MODE_REPEAT: begin
            freq_nxt   = start_r;
            strobe_nxt = (start_r != freq_word);
          end
          MODE_PINGPONG: begin
            state_nxt = (state == ST_SWEEP_FWD) ? ST_SWEEP_REV : ST_SWEEP_FWD;
          end
          default: begin
            state_nxt = ST_HOLD;
          end
        endcase
      end else begin
        freq_nxt   = stepped;
        strobe_nxt = 1'b1;
      end
    end
  end

  // Output registers feeding dds_core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_word   <= '0;
      wave_sel    <= WAVE_DC;
      dc_level    <= DC_PARK;
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      freq_word   <= freq_nxt;
      wave_sel    <= wave_nxt;
      dc_level    <= dc_nxt;
      step_strobe <= strobe_nxt;
      sweep_done  <= done_nxt;
    end
  end

  // Configuration captured only at accept; zero step is promoted to one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= MODE_FIXED;
      start_r <= '0;
      stop_r  <= '0;
      step_r  <= FREQ_WIDTH'(1);
      dwell_r <= '0;
    end else if (accept) begin
      mode_r  <= sweep_mode_t'(cfg_mode);
      start_r <= cfg_start_freq;
      stop_r  <= cfg_stop_freq;
      step_r  <= (cfg_step == '0) ? FREQ_WIDTH'(1) : cfg_step;
      dwell_r <= cfg_dwell;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - randomized and directed bench for dds_sweep_ctrl against a reference model
module tb_dds_sweep_ctrl;

  localparam int FW = 16;
  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [FW-1:0] cfg_start_freq, cfg_stop_freq, cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [2:0]    cfg_wave_sel;
  logic [AW-1:0] cfg_dc_level;
  logic          abort;
  logic [FW-1:0] freq_word;
  logic [2:0]    wave_sel;
  logic [AW-1:0] dc_level;
  logic          busy, step_strobe, sweep_done;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FREQ_WIDTH(FW), .DWELL_WIDTH(DW), .AMP_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick    (sample_tick),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_mode       (cfg_mode),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_wave_sel   (cfg_wave_sel),
    .cfg_dc_level   (cfg_dc_level),
    .abort          (abort),
    .freq_word      (freq_word),
    .wave_sel       (wave_sel),
    .dc_level       (dc_level),
    .busy           (busy),
    .step_strobe    (step_strobe),
    .sweep_done     (sweep_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integers, phase 0 idle, 1 hold, 2 outbound leg, 3 return leg.
  int m_phase, m_freq, m_wave, m_dc, m_strobe, m_done, m_ticks;
  int m_mode, m_start, m_stop, m_step, m_dwell;

  task automatic model_park();
    m_phase = 0; m_freq = 0; m_wave = 4; m_dc = 2048;
    m_strobe = 0; m_done = 0; m_ticks = 0;
  endtask

  task automatic model_dwell_end();
    int tgt;
    tgt = (m_phase == 3) ? m_start : m_stop;
    if (m_freq == tgt) begin
      if (m_mode == 1) begin
        m_done = 1; m_phase = 1;
      end else if (m_mode == 2) begin
        m_strobe = (m_freq != m_start);
        m_freq = m_start;
      end else begin
        m_phase = (m_phase == 2) ? 3 : 2;
      end
    end else begin
      if (tgt > m_freq) m_freq = (m_freq + m_step > tgt) ? tgt : m_freq + m_step;
      else              m_freq = (m_freq - m_step < tgt) ? tgt : m_freq - m_step;
      m_strobe = 1;
    end
  endtask

  task automatic model_edge();
    bit ready;
    ready = (m_phase <= 1) && !abort;
    m_strobe = 0; m_done = 0;
    if (abort) begin
      model_park();
    end else if (cfg_valid && ready) begin
      m_mode  = int'(cfg_mode);
      m_start = int'(cfg_start_freq);
      m_stop  = int'(cfg_stop_freq);
      m_step  = (cfg_step == 0) ? 1 : int'(cfg_step);
      m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
      m_freq  = int'(cfg_start_freq);
      m_wave  = int'(cfg_wave_sel);
      m_dc    = int'(cfg_dc_level);
      m_ticks = 0;
      m_phase = (m_mode == 0) ? 1 : 2;
    end else if (m_phase >= 2 && sample_tick) begin
      m_ticks++;
      if (m_ticks == m_dwell) begin
        m_ticks = 0;
        model_dwell_end();
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("freq_word",   32'(freq_word),   32'(m_freq));
    check_eq("wave_sel",    32'(wave_sel),    32'(m_wave));
    check_eq("dc_level",    32'(dc_level),    32'(m_dc));
    check_eq("busy",        32'(busy),        32'(m_phase >= 2));
    check_eq("step_strobe", 32'(step_strobe), 32'(m_strobe));
    check_eq("sweep_done",  32'(sweep_done),  32'(m_done));
  endtask

  task automatic cycle(input bit t);
    sample_tick = t;
    #1;
    check_eq("cfg_ready", 32'(cfg_ready), 32'((m_phase <= 1) && !abort));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) cycle(period != 0 && (i % period) == period - 1);
  endtask

  task automatic set_cfg(input int mode, input int start, input int stop, input int stp,
                         input int dwell, input int wave, input int dc);
    cfg_mode       = 2'(mode);
    cfg_start_freq = FW'(start);
    cfg_stop_freq  = FW'(stop);
    cfg_step       = FW'(stp);
    cfg_dwell      = DW'(dwell);
    cfg_wave_sel   = 3'(wave);
    cfg_dc_level   = AW'(dc);
  endtask

  task automatic offer(input int mode, input int start, input int stop, input int stp,
                       input int dwell, input int wave, input int dc);
    set_cfg(mode, start, stop, stp, dwell, wave, dc);
    cfg_valid = 1'b1;
    cycle(1'b0);
    cfg_valid = 1'b0;
    set_cfg($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  int strobes, dones;

  initial begin
    rst = 1'b1; sample_tick = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    model_park();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("reset freq", 32'(freq_word), 0);
    check_eq("reset wave", 32'(wave_sel), 4);
    check_eq("reset dc",   32'(dc_level), 2048);
    check_eq("reset busy", 32'(busy), 0);
    check_eq("reset strb", 32'(step_strobe | sweep_done), 0);
    check_eq("reset rdy",  32'(cfg_ready), 1);

    // Fixed tone.
    offer(0, 1000, 0, 0, 1, 0, 100);
    check_eq("fixed freq", 32'(freq_word), 1000);
    run(10, 2);

    // Single sweep upward with dwell 3, tick every 4 clocks.
    offer(1, 100, 130, 10, 3, 1, 300);
    strobes = 0; dones = 0;
    for (int i = 0; i < 60; i++) begin
      cycle((i % 4) == 3);
      strobes += int'(step_strobe);
      dones += int'(sweep_done);
    end
    check_eq("single up end", 32'(freq_word), 130);
    check_eq("single up strobes", 32'(strobes), 3);
    check_eq("single up done", 32'(dones), 1);

    // Single sweep downward with clamp, dwell 0.
    offer(1, 500, 475, 10, 0, 2, 7);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1);
      dones += int'(sweep_done);
    end
    check_eq("single dn end", 32'(freq_word), 475);
    check_eq("single dn done", 32'(dones), 1);

    // Ping-pong.
    offer(3, 0, 20, 10, 1, 3, 9);
    run(20, 1);

    // Repeat near the top of the range.
    offer(2, 65530, 65535, 4, 1, 1, 11);
    run(12, 2);

    // Abort colliding with a config offer and a completing tick.
    offer(1, 0, 1000, 1, 1, 0, 5);
    run(5, 1);
    abort = 1'b1;
    set_cfg(2, 777, 888, 3, 1, 1, 99);
    cfg_valid = 1'b1;
    cycle(1'b1);
    abort = 1'b0; cfg_valid = 1'b0;
    check_eq("abort freq", 32'(freq_word), 0);
    check_eq("abort wave", 32'(wave_sel), 4);
    check_eq("abort dc",   32'(dc_level), 2048);
    offer(1, 40, 60, 5, 2, 2, 1);
    check_eq("post abort accept", 32'(freq_word), 40);
    run(8, 1);

    // Asynchronous reset mid-sweep.
    #2 rst = 1'b1;
    #1;
    check_eq("async rst freq", 32'(freq_word), 0);
    check_eq("async rst wave", 32'(wave_sel), 4);
    check_eq("async rst dc",   32'(dc_level), 2048);
    check_eq("async rst busy", 32'(busy), 0);
    model_park();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int s, e;
      abort = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 9) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 65535 - $urandom_range(0, 40) : $urandom_range(0, 65535);
        e = s + $urandom_range(0, 160) - 80;
        if (e < 0) e = 0;
        if (e > 65535) e = 65535;
        set_cfg($urandom_range(0, 3), s, e, $urandom_range(0, 30), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 4095));
        cfg_valid = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      cycle($urandom_range(0, 2) == 0);
    end
    abort = 1'b0; cfg_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
